// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Package  : piso_pkg
// Desc     : Shared types, constants and the baud divisor helper for the
//            piso_uart_tx serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package piso_pkg;

  // Transmitter frame sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity mode encodings (2'b11 also means no parity)
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Baud select codes
  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_38400  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  // Line rates in bits per second
  localparam int BAUD_RATE_9600   = 9600;
  localparam int BAUD_RATE_19200  = 19200;
  localparam int BAUD_RATE_38400  = 38400;
  localparam int BAUD_RATE_115200 = 115200;

  // Rounded number of clock cycles per bit for a given baud code
  function automatic int baud_div(input int clk_hz, input logic [1:0] code);
    int rate;
    case (code)
      BAUD_9600:   rate = BAUD_RATE_9600;
      BAUD_19200:  rate = BAUD_RATE_19200;
      BAUD_38400:  rate = BAUD_RATE_38400;
      default:     rate = BAUD_RATE_115200;
    endcase
    return (clk_hz + rate / 2) / rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : piso_sync_fifo
// Desc     : Single-clock FIFO with push/pop, full/empty flags and an
//            occupancy count. Read data is presented combinationally from the
//            head entry. DEPTH must be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module piso_sync_fifo
  import piso_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level;
  logic              do_push;
  logic              do_pop;

  // Requests that would overflow or underflow are dropped
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign count = level;
  assign dout  = mem[rd_ptr];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : piso_uart_tx
// Desc     : Parallel-in serial-out UART transmitter. Words arrive on a
//            valid/ready handshake, are queued, and are sent LSB-first with a
//            start bit, optional odd/even parity and one or two stop bits.
//            Queued frames are sent back-to-back with no idle gap.
// Config   : PISO_FIFO_EN - defined: FIFO_DEPTH-entry input FIFO;
//                           undefined: single holding register.
// Revision : 1.0 - initial release
// ============================================================================
module piso_uart_tx
  import piso_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          DCLK,
  input  logic                          RST,
  input  logic                          DVALID,
  output logic                          DREADY,
  input  logic [DATA_W-1:0]             DI,
  input  logic [1:0]                    CTRL_PARITY,
  input  logic                          CTRL_STOP2,
  input  logic [1:0]                    CTRL_BAUD_RATE,
  output logic                          TXD,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   DCOUNT
);

  localparam int CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int BIT_W       = $clog2(DATA_W);
  localparam int DIV_9600    = baud_div(CLK_HZ, BAUD_9600);
  localparam int DIV_19200   = baud_div(CLK_HZ, BAUD_19200);
  localparam int DIV_38400   = baud_div(CLK_HZ, BAUD_38400);
  localparam int DIV_115200  = baud_div(CLK_HZ, BAUD_115200);
  // The slowest rate has the largest divisor and sets the counter width
  localparam int CNT_W       = $clog2(DIV_9600 + 1);

  // Queue interface shared by both storage options
  logic              push;
  logic              pop;
  logic              q_full;
  logic              q_empty;
  logic [DATA_W-1:0] q_data;
  logic [CW-1:0]     q_count;

  assign DREADY = !q_full && !RST;
  assign push   = DVALID && DREADY;
  assign DCOUNT = q_count;

`ifdef PISO_FIFO_EN
  piso_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (DCLK),
    .rst   (RST),
    .push  (push),
    .din   (DI),
    .pop   (pop),
    .dout  (q_data),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );
`else
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;

  // Holding register occupancy; push and pop never coincide since push needs it empty
  always_ff @(posedge DCLK) begin
    if (RST) begin
      hold_valid <= 1'b0;
    end else if (push) begin
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  // Holding register payload
  always_ff @(posedge DCLK) begin
    if (push) begin
      hold_data <= DI;
    end
  end

  assign q_full  = hold_valid;
  assign q_empty = !hold_valid;
  assign q_data  = hold_data;
  assign q_count = {{(CW-1){1'b0}}, hold_valid};
`endif

  // Frame sequencer and per-frame context
  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  baud_cnt;
  logic [CNT_W-1:0]  div_m1;
  logic [BIT_W-1:0]  bit_cnt;
  logic              stop_cnt;
  logic [DATA_W-1:0] frame_data;
  logic [1:0]        par_mode;
  logic              stop2;
  logic [1:0]        baud_code;
  logic              tick;
  logic              last_bit;
  logic              last_stop;
  logic              par_en;
  logic              par_bit;
  logic              txd_nx;

  // Divisor for the frame in flight, from the latched baud code
  always_comb begin
    div_m1 = CNT_W'(DIV_115200 - 1);
    case (baud_code)
      BAUD_9600:   div_m1 = CNT_W'(DIV_9600 - 1);
      BAUD_19200:  div_m1 = CNT_W'(DIV_19200 - 1);
      BAUD_38400:  div_m1 = CNT_W'(DIV_38400 - 1);
      default:     div_m1 = CNT_W'(DIV_115200 - 1);
    endcase
  end

  assign tick      = (state != IDLE) && (baud_cnt == div_m1);
  assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));
  assign last_stop = (stop_cnt == stop2);
  assign par_en    = (par_mode == PAR_ODD) || (par_mode == PAR_EVEN);
  // Odd mode inverts the even-parity bit so the total count of ones is odd
  assign par_bit   = (^frame_data) ^ (par_mode == PAR_ODD);

  // Next-state, pop request and serial bit for the current state
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    txd_nx   = 1'b1;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          state_nx = START;
          pop      = 1'b1;
        end
      end
      START: begin
        txd_nx = 1'b0;
        if (tick) begin
          state_nx = DATA;
        end
      end
      DATA: begin
        txd_nx = frame_data[bit_cnt];
        if (tick && last_bit) begin
          state_nx = par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        txd_nx = par_bit;
        if (tick) begin
          state_nx = STOP;
        end
      end
      STOP: begin
        if (tick && last_stop) begin
          if (!q_empty) begin
            state_nx = START;
            pop      = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge DCLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Frame context capture on pop, then baud/bit/stop counting while active
  always_ff @(posedge DCLK) begin
    if (RST) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      frame_data <= '0;
      par_mode   <= PAR_NONE;
      stop2      <= 1'b0;
      baud_code  <= BAUD_115200;
    end else if (pop) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      frame_data <= q_data;
      par_mode   <= CTRL_PARITY;
      stop2      <= CTRL_STOP2;
      baud_code  <= CTRL_BAUD_RATE;
    end else if (state != IDLE) begin
      if (tick) begin
        baud_cnt <= '0;
        if (state == DATA) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (state == STOP) begin
          stop_cnt <= 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  // Registered line and status outputs, one cycle behind the state
  always_ff @(posedge DCLK) begin
    if (RST) begin
      TXD  <= 1'b1;
      BUSY <= 1'b0;
    end else begin
      TXD  <= txd_nx;
      BUSY <= (state != IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_uart_tx
// Desc     : Directed self-checking bench for piso_uart_tx at
//            CLK_HZ=1_152_000 (divisors 120/60/30/10).
// Config   : PISO_FIFO_EN - selects FIFO-mode expectations for queue depth.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_uart_tx;

  localparam int DATA_W     = 8;
  localparam int CLK_HZ     = 1_152_000;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;
`ifdef PISO_FIFO_EN
  localparam int EXP_BLOCK_AT = FIFO_DEPTH + 1;
  localparam int EXP_QMAX     = FIFO_DEPTH;
  localparam int N_QUEUED     = 2;
`else
  localparam int EXP_BLOCK_AT = 1;
  localparam int EXP_QMAX     = 1;
  localparam int N_QUEUED     = 1;
`endif

  logic              clk = 1'b0;
  logic              RST = 1'b1;
  logic              DVALID = 1'b0;
  logic              DREADY;
  logic [DATA_W-1:0] DI = '0;
  logic [1:0]        CTRL_PARITY = 2'b00;
  logic              CTRL_STOP2 = 1'b0;
  logic [1:0]        CTRL_BAUD_RATE = 2'b11;
  logic              TXD;
  logic              BUSY;
  logic [CW-1:0]     DCOUNT;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;

  piso_uart_tx #(
    .DATA_W     (DATA_W),
    .CLK_HZ     (CLK_HZ),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .DCLK           (clk),
    .RST            (RST),
    .DVALID         (DVALID),
    .DREADY         (DREADY),
    .DI             (DI),
    .CTRL_PARITY    (CTRL_PARITY),
    .CTRL_STOP2     (CTRL_STOP2),
    .CTRL_BAUD_RATE (CTRL_BAUD_RATE),
    .TXD            (TXD),
    .BUSY           (BUSY),
    .DCOUNT         (DCOUNT)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (BUSY === 1'b1) busy_cnt++;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Offer one word; returns just after the accepting edge
  task automatic push_word(input logic [7:0] d, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    DI = d;
    DVALID = 1'b1;
    while (DREADY !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (DREADY === 1'b1) begin
      @(posedge clk);
      ok = 1'b1;
    end
    #1 DVALID = 1'b0;
  endtask

  // Wait for a start bit, then sample nbits bit periods of div cycles each
  task automatic capture(input int nbits, input int div, output logic [15:0] bits,
                         output int glitches, output int gap, output bit timeout);
    bits = '1;
    glitches = 0;
    timeout = 1'b0;
    @(negedge clk);
    gap = 0;
    while (TXD !== 1'b0 && gap < 2000) begin
      @(negedge clk);
      gap++;
    end
    if (TXD !== 1'b0) begin
      timeout = 1'b1;
      return;
    end
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < div; c++) begin
        if (!(i == 0 && c == 0)) @(negedge clk);
        if (c == 0) bits[i] = TXD;
        else if (TXD !== bits[i]) glitches++;
      end
    end
  endtask

  task automatic test_reset();
    DVALID = 1'b1;
    DI = 8'hEE;
    repeat (3) @(negedge clk);
    total++; if (TXD !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", TXD); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    total++; if (DCOUNT !== 3'd0) begin bad++; $display("FAIL reset_dcount: got %0d want 0", DCOUNT); end
    total++; if (DREADY !== 1'b0) begin bad++; $display("FAIL reset_dready: got %b want 0", DREADY); end
    DVALID = 1'b0;
    @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    total++; if (DREADY !== 1'b1) begin bad++; $display("FAIL post_reset_dready: got %b want 1", DREADY); end
    total++; if (DCOUNT !== 3'd0) begin bad++; $display("FAIL post_reset_dcount: got %0d want 0", DCOUNT); end
  endtask

  task automatic test_8n1();
    logic [15:0] bits;
    int gl, gap;
    bit to, ok;
    CTRL_PARITY = 2'b00; CTRL_STOP2 = 1'b0; CTRL_BAUD_RATE = 2'b11;
    busy_cnt = 0;
    push_word(8'hA5, ok);
    total++; if (!ok) begin bad++; $display("FAIL 8n1_push: got no accept want accept"); end
    @(negedge clk);
    total++; if (DCOUNT !== 3'd1) begin bad++; $display("FAIL 8n1_dcount_k: got %0d want 1", DCOUNT); end
    total++; if ({BUSY, TXD} !== 2'b01) begin bad++; $display("FAIL 8n1_idle_k: got busy/txd %b want 01", {BUSY, TXD}); end
    @(negedge clk);
    total++; if (DCOUNT !== 3'd0) begin bad++; $display("FAIL 8n1_dcount_k1: got %0d want 0", DCOUNT); end
    total++; if ({BUSY, TXD} !== 2'b01) begin bad++; $display("FAIL 8n1_idle_k1: got busy/txd %b want 01", {BUSY, TXD}); end
    capture(10, 10, bits, gl, gap, to);
    total++; if (to || gap !== 0) begin bad++; $display("FAIL 8n1_latency: got gap %0d to %0d want gap 0", gap, to); end
    total++; if (bits[9:0] !== {1'b1, 8'hA5, 1'b0}) begin bad++; $display("FAIL 8n1_bits: got %b want %b", bits[9:0], {1'b1, 8'hA5, 1'b0}); end
    total++; if (gl !== 0) begin bad++; $display("FAIL 8n1_bit_width: got %0d glitches want 0", gl); end
    repeat (5) @(negedge clk);
    total++; if (busy_cnt !== 100) begin bad++; $display("FAIL 8n1_busy_len: got %0d want 100", busy_cnt); end
  endtask

  task automatic test_parity();
    logic [1:0]  par_t [4];
    logic        stop_t [4];
    logic [7:0]  d_t [4];
    int          nb_t [4];
    logic [15:0] exp_t [4];
    logic [15:0] bits, mask;
    int gl, gap;
    bit to, ok;
    par_t  = '{2'b01, 2'b10, 2'b01, 2'b11};
    stop_t = '{1'b0, 1'b1, 1'b0, 1'b0};
    d_t    = '{8'h03, 8'h03, 8'h07, 8'h5A};
    nb_t   = '{11, 12, 11, 10};
    exp_t  = '{{5'b0, 1'b1, 1'b1, 8'h03, 1'b0},
               {4'b0, 2'b11, 1'b0, 8'h03, 1'b0},
               {5'b0, 1'b1, 1'b0, 8'h07, 1'b0},
               {6'b0, 1'b1, 8'h5A, 1'b0}};
    CTRL_BAUD_RATE = 2'b11;
    for (int t = 0; t < 4; t++) begin
      CTRL_PARITY = par_t[t];
      CTRL_STOP2  = stop_t[t];
      busy_cnt = 0;
      mask = 16'((32'd1 << nb_t[t]) - 1);
      push_word(d_t[t], ok);
      capture(nb_t[t], 10, bits, gl, gap, to);
      total++; if (!ok || to || gap !== 2) begin bad++; $display("FAIL par%0d_start: got gap %0d ok %0d to %0d want gap 2", t, gap, ok, to); end
      total++; if ((bits & mask) !== exp_t[t]) begin bad++; $display("FAIL par%0d_bits: got %b want %b", t, bits & mask, exp_t[t]); end
      repeat (5) @(negedge clk);
      total++; if (busy_cnt !== nb_t[t] * 10) begin bad++; $display("FAIL par%0d_busy_len: got %0d want %0d", t, busy_cnt, nb_t[t] * 10); end
    end
  endtask

  task automatic test_baud_rates();
    logic [1:0] code_t [3];
    int         div_t [3];
    logic [15:0] bits;
    int gl, gap;
    bit to, ok;
    code_t = '{2'b00, 2'b01, 2'b10};
    div_t  = '{120, 60, 30};
    CTRL_PARITY = 2'b00; CTRL_STOP2 = 1'b0;
    for (int t = 0; t < 3; t++) begin
      CTRL_BAUD_RATE = code_t[t];
      busy_cnt = 0;
      push_word(8'h81, ok);
      capture(10, div_t[t], bits, gl, gap, to);
      total++; if (!ok || to || gap !== 2) begin bad++; $display("FAIL baud%0d_start: got gap %0d ok %0d to %0d want gap 2", t, gap, ok, to); end
      total++; if (bits[9:0] !== {1'b1, 8'h81, 1'b0} || gl !== 0) begin bad++; $display("FAIL baud%0d_bits: got %b glitches %0d want %b glitches 0", t, bits[9:0], gl, {1'b1, 8'h81, 1'b0}); end
      repeat (5) @(negedge clk);
      total++; if (busy_cnt !== 10 * div_t[t]) begin bad++; $display("FAIL baud%0d_busy_len: got %0d want %0d", t, busy_cnt, 10 * div_t[t]); end
    end
  endtask

  task automatic test_midframe_ctrl();
    logic [15:0] bits;
    int gl, gap;
    bit to, ok1, ok2;
    CTRL_PARITY = 2'b00; CTRL_STOP2 = 1'b0; CTRL_BAUD_RATE = 2'b11;
    push_word(8'h55, ok1);
    push_word(8'h07, ok2);
    CTRL_PARITY = 2'b10;
    capture(10, 10, bits, gl, gap, to);
    total++; if (!ok1 || !ok2 || to) begin bad++; $display("FAIL mid_f1_start: got ok %0d%0d to %0d want 110", ok1, ok2, to); end
    total++; if (bits[9:0] !== {1'b1, 8'h55, 1'b0}) begin bad++; $display("FAIL mid_f1_bits: got %b want %b", bits[9:0], {1'b1, 8'h55, 1'b0}); end
    capture(11, 10, bits, gl, gap, to);
    total++; if (to || gap !== 0) begin bad++; $display("FAIL mid_f2_gap: got gap %0d to %0d want 0", gap, to); end
    total++; if (bits[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin bad++; $display("FAIL mid_f2_bits: got %b want %b", bits[10:0], {1'b1, 1'b1, 8'h07, 1'b0}); end
    repeat (5) @(negedge clk);
    CTRL_PARITY = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6];
    logic [CW-1:0] cnt_at_block, dcnt1;
    int accepted, first_block, n;
    words = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    accepted = 0; first_block = -1; n = 0;
    cnt_at_block = '1; dcnt1 = '1;
    CTRL_PARITY = 2'b00; CTRL_STOP2 = 1'b0; CTRL_BAUD_RATE = 2'b11;
    busy_cnt = 0;
    fork
      begin
        @(negedge clk);
        DI = words[0];
        DVALID = 1'b1;
        while (accepted < 6 && n < 3000) begin
          if (DREADY === 1'b1) begin
            @(posedge clk);
            accepted++;
            #1 if (accepted < 6) DI = words[accepted];
            @(negedge clk);
            if (accepted == 1) dcnt1 = DCOUNT;
          end else begin
            if (first_block < 0) begin
              first_block = accepted;
              cnt_at_block = DCOUNT;
            end
            @(negedge clk);
          end
          n++;
        end
        DVALID = 1'b0;
      end
      begin
        logic [15:0] bits;
        int gl, gap;
        bit to;
        for (int f = 0; f < 6; f++) begin
          capture(10, 10, bits, gl, gap, to);
          total++; if (to) begin bad++; $display("FAIL b2b_f%0d_timeout: got none want frame", f); end
          total++; if (bits[9:0] !== {1'b1, words[f], 1'b0} || gl !== 0) begin bad++; $display("FAIL b2b_f%0d_bits: got %b glitches %0d want %b", f, bits[9:0], gl, {1'b1, words[f], 1'b0}); end
          if (f > 0) begin
            total++; if (gap !== 0) begin bad++; $display("FAIL b2b_f%0d_gap: got %0d want 0", f, gap); end
          end
        end
      end
    join
    repeat (5) @(negedge clk);
    total++; if (accepted !== 6) begin bad++; $display("FAIL b2b_accepted: got %0d want 6", accepted); end
    total++; if (dcnt1 !== 3'd1) begin bad++; $display("FAIL b2b_dcount_first: got %0d want 1", dcnt1); end
    total++; if (first_block !== EXP_BLOCK_AT) begin bad++; $display("FAIL b2b_block_at: got %0d want %0d", first_block, EXP_BLOCK_AT); end
    total++; if (cnt_at_block !== CW'(EXP_QMAX)) begin bad++; $display("FAIL b2b_dcount_full: got %0d want %0d", cnt_at_block, EXP_QMAX); end
    total++; if (busy_cnt !== 600) begin bad++; $display("FAIL b2b_busy_len: got %0d want 600", busy_cnt); end
    total++; if (DCOUNT !== 3'd0 || BUSY !== 1'b0) begin bad++; $display("FAIL b2b_drained: got dcount %0d busy %b want 0 0", DCOUNT, BUSY); end
  endtask

  task automatic test_reset_midframe();
    bit ok, ok_all;
    int n, stray;
    CTRL_PARITY = 2'b00; CTRL_STOP2 = 1'b0; CTRL_BAUD_RATE = 2'b11;
    push_word(8'h3C, ok); ok_all = ok;
    push_word(8'hC3, ok); ok_all &= ok;
`ifdef PISO_FIFO_EN
    push_word(8'h99, ok); ok_all &= ok;
`endif
    n = 0;
    @(negedge clk);
    while (TXD !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++; if (!ok_all || TXD !== 1'b0) begin bad++; $display("FAIL rst_mid_start: got txd %b ok %0d want 0 1", TXD, ok_all); end
    repeat (43) @(negedge clk);
    total++; if (DCOUNT !== CW'(N_QUEUED) || BUSY !== 1'b1) begin bad++; $display("FAIL rst_mid_queued: got dcount %0d busy %b want %0d 1", DCOUNT, BUSY, N_QUEUED); end
    RST = 1'b1;
    #1;
    total++; if (DREADY !== 1'b0) begin bad++; $display("FAIL rst_mid_dready: got %b want 0", DREADY); end
    @(posedge clk);
    #1 RST = 1'b0;
    @(negedge clk);
    total++; if (TXD !== 1'b1 || BUSY !== 1'b0) begin bad++; $display("FAIL rst_mid_line: got txd %b busy %b want 1 0", TXD, BUSY); end
    total++; if (DCOUNT !== 3'd0) begin bad++; $display("FAIL rst_mid_dcount: got %0d want 0", DCOUNT); end
    stray = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (TXD !== 1'b1 || BUSY !== 1'b0) stray++;
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL rst_mid_no_frames: got %0d active cycles want 0", stray); end
    total++; if (DREADY !== 1'b1) begin bad++; $display("FAIL rst_mid_ready_after: got %b want 1", DREADY); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_baud_rates();
    test_midframe_ctrl();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_uart_tx.md
# piso_uart_tx

Parametrised second-generation parallel-to-serial UART transmitter. It accepts DATA_W-bit words on a valid/ready handshake into an optional input FIFO and serialises them LSB-first on TXD. Each frame has a start bit, optional odd or even parity, and one or two stop bits. Frames are sent back-to-back with no idle gap while data is queued. It sits between the parallel data source (DCLK domain) and the board-level serial line.

## Interface
- DATA_W, 8: data bits per frame, 5..9.
- CLK_HZ, 50_000_000: DCLK frequency; bit divisors are derived from it at elaboration.
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥2. Used only with PISO_FIFO_EN.
- DCLK  in  1  single clock. One clock; reset is synchronous and active-high.
- RST  in  1  synchronous, active-high reset.
- DVALID  in  1  DI holds a valid word.
- DREADY  out  1  block can accept a word; a transfer occurs on an edge where DVALID && DREADY.
- DI  in  DATA_W  parallel data.
- CTRL_PARITY  in  2  parity mode: 00 none, 01 odd, 10 even, 11 none.
- CTRL_STOP2  in  1  1 selects two stop bits, 0 selects one.
- CTRL_BAUD_RATE  in  2  baud select: 00 9600, 01 19200, 10 38400, 11 115200.
- TXD  out  1  serial output; idle high.
- BUSY  out  1  a frame is in progress (FSM not IDLE).
- DCOUNT  out  $clog2(FIFO_DEPTH)+1  words queued but not yet started.

## Operation
- Bit divisor: DIV = round(CLK_HZ / baud). DIV is a constant per CTRL_BAUD_RATE code. Every bit lasts exactly DIV DCLK cycles.
- Baud counter:
  - Clears on frame start.
  - Counts 0..DIV-1 and issues a tick at DIV-1.
  - Does not run in IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: moves to START on the first edge where the queue is non-empty. That same edge pops the word and latches CTRL_PARITY, CTRL_STOP2 and CTRL_BAUD_RATE for the whole frame.
  - START: TXD=0 for one bit time, then DATA.
  - DATA: TXD=data[bit_cnt], with bit_cnt running 0..DATA_W-1. After the last data bit the FSM goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY: outputs one bit time of parity, then STOP.
    - Odd mode: the bit makes the total number of ones (data plus parity) odd.
    - Even mode: the bit makes that total even.
  - STOP: TXD=1 for one bit time (two if CTRL_STOP2 was latched).
  - On the final stop tick: if the queue is non-empty, go directly to START with a new pop; otherwise go to IDLE.
- Control inputs that change mid-frame affect only the next frame.
- TXD, BUSY and DCOUNT are registered. DREADY is combinational: !full && !RST.

## Timing
- Reset values (while RST is high and on the first edge after): TXD=1, BUSY=0, DCOUNT=0, FSM=IDLE, FIFO empty, DREADY=0.
- Accept-to-TXD latency, from an idle, empty block: accepted on edge k, DCOUNT=1 after edge k. TXD falls and BUSY rises after edge k+2.
- Frame length is (1 + DATA_W + P + S) × DIV cycles, where P = 1 if parity is enabled (else 0) and S = stop bits.
- Back-to-back: the next start bit begins on the cycle immediately after the last stop bit.
- Full FIFO: DREADY=0. A push and pop on the same edge is not possible, because a push requires not-full.
- Empty FIFO: there is no bypass; a word pushed at edge k is first poppable at edge k+1.
- Reset mid-frame: the frame is aborted. On the reset edge TXD=1 and queued words are discarded.

## Configuration
- PISO_FIFO_EN defined: an input FIFO of FIFO_DEPTH entries. DREADY stays high while frames are in flight until the FIFO is full.
- PISO_FIFO_EN undefined: a single holding register.
  - DREADY=1 only when the register is empty.
  - The register empties on the pop at frame start, so one word can wait while the current frame transmits.
  - DCOUNT is 0 or 1.

## Structure
- Package piso_pkg holds:
  - the state_t enum;
  - the parity-mode localparams (PAR_NONE, PAR_ODD, PAR_EVEN);
  - the baud-rate localparams (9600, 19200, 38400, 115200);
  - function baud_div(CLK_HZ, code), which returns the rounded divisor.
- Sub-module piso_sync_fifo (DATA_W, DEPTH): synchronous FIFO with push/pop, full/empty and count. It is instantiated only under PISO_FIFO_EN.

## Test plan
- CLK_HZ=1_152_000, code 11 (DIV=10), 8N1, push 0xA5. TXD reads 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. BUSY is high for 100 cycles.
- Same clock, odd parity, push 0x03. Parity bit is 1. With even parity the bit is 0. Two stop bits lengthen the frame to 120 cycles.
- FIFO_DEPTH=4, DVALID held high with 0x11..0x16.
  - DREADY drops after the fifth acceptance: four queued plus one in flight.
  - All six frames appear contiguous with no idle cycle.
  - DCOUNT tracks each push and pop.
- CLK_HZ=1_152_000, code 00 (DIV=120). Each bit time measures exactly 120 cycles.
- Change CTRL_PARITY from none to even mid-frame. The current frame has no parity bit; the next frame carries the even parity bit.
- Assert RST for 1 cycle during DATA bit 3 with 2 words queued. After the reset edge TXD=1, BUSY=0 and DCOUNT=0, and no further frames follow.
